normalize_shifter: RTL and testbench
====================================

// Module: normalize_shifter
// PURPOSE
//  Two-stage pipelined left-normalizer. It consumes the leading-zero count from an embedded
//  count_leading_zeros instance and shifts the operand so its MSB is 1.
//  Sits in the int-to-float / FP post-add path, directly downstream of the LZ counter.
//  Uses valid/ready handshakes on both sides and stalls cleanly under backpressure.
// PARAMETERS
//  DATA_WIDTH   32   operand width; legal values 32 or 24 only (CLZ constraint)
//  EXP_WIDTH    8    exponent width; used only when NORMALIZE_EXP_ADJUST_EN is defined
// PORTS
//  clk_i          in   1                   clock, rising edge
//  rst_n_i        in   1                   async active-low reset
//  operand_i      in   DATA_WIDTH          value to normalize
//  exponent_i     in   EXP_WIDTH           unbiased-agnostic exponent tag (macro only)
//  valid_i        in   1                   operand_i/exponent_i valid
//  ready_o        out  1                   block accepts input this cycle
//  normalized_o   out  DATA_WIDTH          operand_i << shift_o
//  shift_o        out  $clog2(DATA_WIDTH)  leading-zero count applied
//  is_zero_o      out  1                   operand was all zero
//  exponent_o     out  EXP_WIDTH           exponent_i - shift_o (macro only)
//  underflow_o    out  1                   exponent_i < shift_o, unsigned (macro only)
//  valid_o        out  1                   outputs valid
//  ready_i        in   1                   downstream accepts output
// BEHAVIOUR
//  - Reset: all pipeline registers and outputs are 0; valid_o=0. ready_o=1 immediately after reset.
//  - Transfer rules: input is accepted on valid_i&&ready_o; output is consumed on valid_o&&ready_i.
//  - S1 (register stage 1): captures operand, CLZ count and all-zero flag. CLZ is combinational on operand_i.
//  - S2 (register stage 2): captures the shifted operand. normalized = S1.operand << S1.count, logical, zero fill.
//  - Latency: exactly 2 cycles from accept to valid_o, with no stall. Throughput is 1 per cycle.
//  - Stall: s2_en = !s2_valid || ready_i; s1_en = !s1_valid || s2_en; ready_o = s1_en.
//    ready_o is combinational from ready_i. There are no bubbles while the pipe is full and draining.
//  - While valid_o=1 && ready_i=0, all outputs hold stable.
//  - A stage's data regs load only when that stage is enabled. Its valid bit loads from the upstream valid.
//  - All-zero operand: is_zero_o=1, normalized_o=0, shift_o=0 (CLZ count is overridden).
//  - Operand with MSB set: shift_o=0, normalized_o=operand.
//  - Reset asserted mid-operation: in-flight items are dropped asynchronously; valid_o drops at once.
//  - Simultaneous accept and output handshake while full: both occur and the pipe stays full.
// CONFIGURATION
//  - Macro NORMALIZE_EXP_ADJUST_EN.
//  - Defined:
//    - exponent_i is carried in S1.
//    - S2 computes exponent_o = exponent_i - shift_o, modulo 2^EXP_WIDTH.
//    - underflow_o = (exponent_i < shift_o).
//    - Zero operand gives exponent_o=0 and underflow_o=0.
//  - Undefined: exponent_i is ignored; exponent_o and underflow_o are tied to 0 and no exponent regs exist.
//    Ports remain present.
// STRUCTURE
//  - Package normalize_pkg:
//    - localparam SHIFT_WIDTH = $clog2(DATA_WIDTH) helper.
//    - typedef struct s1_t {operand, count, is_zero, exponent}.
//    - typedef struct s2_t {normalized, shift, is_zero, exponent, underflow}.
//  - One sub-module: count_leading_zeros (existing codebase module), instanced on operand_i.
//    Its is_all_zero_o feeds the S1 is_zero flag.
//  - The shifter is inline; no further hierarchy.
// TESTING
//  1. DATA_WIDTH=32, operand 0x0000_0001, ready_i=1
//     -> 2 cycles later normalized_o=0x8000_0000, shift_o=31, is_zero_o=0.
//  2. Operand 0x8000_0000 -> normalized_o=0x8000_0000, shift_o=0.
//     Operand 0x0000_0000 -> is_zero_o=1, normalized_o=0, shift_o=0.
//  3. DATA_WIDTH=24, operand 0x000F00 -> normalized_o=0xF00000, shift_o=12.
//  4. Stream 0x1,0x2,0x4,0x8 back-to-back; hold ready_i=0 for 3 cycles at the 2nd output.
//     -> valid_o and data stay stable, ready_o falls once both stages are full.
//     -> Outputs arrive in order with shifts 31,30,29,28 and no loss or duplication.
//  5. With NORMALIZE_EXP_ADJUST_EN: exponent_i=10, operand 0x0000_0100 -> shift_o=23, exponent_o=0xF3, underflow_o=1.
//     exponent_i=40, same operand -> exponent_o=17, underflow_o=0.
//  6. Two items in flight, assert rst_n_i low for 1 cycle
//     -> valid_o=0 at once, all outputs 0, ready_o=1 after release, next item has 2-cycle latency.

Source files
------------

// File: rtl/normalize_pkg.sv
// Shared types for the two-stage normalize pipeline. Fields are sized for the widest
// legal operand (32) so both 24- and 32-bit builds share one set of types.
package normalize_pkg;

    localparam int DATA_WIDTH_MAX = 32;
    localparam int SHIFT_WIDTH    = $clog2(DATA_WIDTH_MAX);
    localparam int EXP_WIDTH_MAX  = 16;

    typedef struct packed {
        logic [DATA_WIDTH_MAX-1:0] operand;
        logic [SHIFT_WIDTH-1:0]    count;
        logic                      is_zero;
        logic [EXP_WIDTH_MAX-1:0]  exponent;
    } s1_t;

    typedef struct packed {
        logic [DATA_WIDTH_MAX-1:0] normalized;
        logic [SHIFT_WIDTH-1:0]    shift;
        logic                      is_zero;
        logic [EXP_WIDTH_MAX-1:0]  exponent;
        logic                      underflow;
    } s2_t;

    // Returns {borrow, difference}; borrow is set exactly when exp < shift (unsigned).
    function automatic logic [EXP_WIDTH_MAX:0] exp_sub(
        input logic [EXP_WIDTH_MAX-1:0] exp,
        input logic [SHIFT_WIDTH-1:0]   shift
    );
        logic [EXP_WIDTH_MAX:0] ext_exp;
        logic [EXP_WIDTH_MAX:0] ext_shift;
        ext_exp   = {1'b0, exp};
        ext_shift = {{(EXP_WIDTH_MAX + 1 - SHIFT_WIDTH){1'b0}}, shift};
        return ext_exp - ext_shift;
    endfunction

endpackage

// File: rtl/count_leading_zeros.sv
// Combinational leading-zero counter; count is 0 for an all-zero input and
// is_all_zero_o flags that case separately.
module count_leading_zeros #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH)-1:0] count_o,
    output logic                     is_all_zero_o
);

    localparam int CW = $clog2(WIDTH);

    // Scan LSB to MSB so the highest set bit determines the final count.
    always_comb begin
        count_o = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end else begin
                count_o = count_o;
            end
        end
    end

    assign is_all_zero_o = ~|data_i;

endmodule

// File: rtl/normalize_shifter.sv
// Two-stage pipelined left-normalizer with valid/ready on both sides.
// Optional exponent adjust path enabled by defining NORMALIZE_EXP_ADJUST_EN.
module normalize_shifter
    import normalize_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [DATA_WIDTH-1:0]         operand_i,
    input  logic [EXP_WIDTH-1:0]          exponent_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [DATA_WIDTH-1:0]         normalized_o,
    output logic [$clog2(DATA_WIDTH)-1:0] shift_o,
    output logic                          is_zero_o,
    output logic [EXP_WIDTH-1:0]          exponent_o,
    output logic                          underflow_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    logic [SHIFT_WIDTH-1:0] clz_count_s;
    logic                   clz_zero_s;
    logic                   s1_en_s;
    logic                   s2_en_s;
    logic [DATA_WIDTH-1:0]  s1_operand_s;
    logic [DATA_WIDTH-1:0]  shifted_s;
    logic                   unused_s;

    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;
    logic s1_valid_d;
    logic s1_valid_q;
    logic s2_valid_d;
    logic s2_valid_q;

    count_leading_zeros #(
        .WIDTH(DATA_WIDTH)
    ) u_clz (
        .data_i       (operand_i),
        .count_o      (clz_count_s),
        .is_all_zero_o(clz_zero_s)
    );

    assign s2_en_s = !s2_valid_q || ready_i;
    assign s1_en_s = !s1_valid_q || s2_en_s;
    assign ready_o = s1_en_s;

    assign s1_operand_s = s1_q.operand[DATA_WIDTH-1:0];
    assign shifted_s    = s1_operand_s << s1_q.count;

`ifdef NORMALIZE_EXP_ADJUST_EN
    logic [EXP_WIDTH_MAX:0] exp_diff_s;
    assign exp_diff_s = exp_sub(s1_q.exponent, s1_q.count);
`endif

    // Stage 1 next state: operand, CLZ count and zero flag captured on accept.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (s1_en_s) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_d.operand = DATA_WIDTH_MAX'(operand_i);
                // An all-zero operand reports a shift of 0, not the raw width.
                s1_d.count   = clz_zero_s ? {SHIFT_WIDTH{1'b0}} : clz_count_s;
                s1_d.is_zero = clz_zero_s;
`ifdef NORMALIZE_EXP_ADJUST_EN
                s1_d.exponent = EXP_WIDTH_MAX'(exponent_i);
`else
                s1_d.exponent = {EXP_WIDTH_MAX{1'b0}};
`endif
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: shifted operand and adjusted exponent.
    always_comb begin
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s2_en_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.normalized = DATA_WIDTH_MAX'(shifted_s);
                s2_d.shift      = s1_q.count;
                s2_d.is_zero    = s1_q.is_zero;
`ifdef NORMALIZE_EXP_ADJUST_EN
                if (s1_q.is_zero) begin
                    s2_d.exponent  = {EXP_WIDTH_MAX{1'b0}};
                    s2_d.underflow = 1'b0;
                end else begin
                    s2_d.exponent  = exp_diff_s[EXP_WIDTH_MAX-1:0];
                    s2_d.underflow = exp_diff_s[EXP_WIDTH_MAX];
                end
`else
                s2_d.exponent  = {EXP_WIDTH_MAX{1'b0}};
                s2_d.underflow = 1'b0;
`endif
            end else begin
                s2_d = s2_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset drops any in-flight item immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign normalized_o = s2_q.normalized[DATA_WIDTH-1:0];
    assign shift_o      = s2_q.shift;
    assign is_zero_o    = s2_q.is_zero;
    assign valid_o      = s2_valid_q;

`ifdef NORMALIZE_EXP_ADJUST_EN
    assign exponent_o  = s2_q.exponent[EXP_WIDTH-1:0];
    assign underflow_o = s2_q.underflow;
`else
    assign exponent_o  = {EXP_WIDTH{1'b0}};
    assign underflow_o = 1'b0;
`endif

    // Upper struct bits are constant in narrower builds and exponent fields are unused without the macro.
    assign unused_s = ^{s1_q.operand, s2_q.normalized, s1_q.exponent, s2_q.exponent,
                        s2_q.underflow, exponent_i};

endmodule

// File: tb/tb_normalize_shifter.sv
// Directed bench for normalize_shifter: vector table plus stall, stream and reset sequences.
module tb_normalize_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] operand, normalized;
    logic [7:0]  exponent_in, exponent_out;
    logic        valid_in, ready_out, valid_out, ready_in, is_zero, underflow;
    logic [4:0]  shift;

    logic [23:0] op24, norm24;
    logic [7:0]  exp24_in, exp24_out;
    logic        v24_in, r24_out, v24_out, r24_in, z24, uf24;
    logic [4:0]  sh24;

    int checks   = 0;
    int failures = 0;

    normalize_shifter #(.DATA_WIDTH(32), .EXP_WIDTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .operand_i(operand), .exponent_i(exponent_in),
        .valid_i(valid_in), .ready_o(ready_out), .normalized_o(normalized), .shift_o(shift),
        .is_zero_o(is_zero), .exponent_o(exponent_out), .underflow_o(underflow),
        .valid_o(valid_out), .ready_i(ready_in)
    );

    normalize_shifter #(.DATA_WIDTH(24), .EXP_WIDTH(8)) dut24 (
        .clk_i(clk), .rst_n_i(rst_n), .operand_i(op24), .exponent_i(exp24_in),
        .valid_i(v24_in), .ready_o(r24_out), .normalized_o(norm24), .shift_o(sh24),
        .is_zero_o(z24), .exponent_o(exp24_out), .underflow_o(uf24),
        .valid_o(v24_out), .ready_i(r24_in)
    );

    typedef struct {
        logic [31:0] op;
        logic [7:0]  exp_in;
        logic [31:0] norm;
        logic [4:0]  sh;
        logic        zero;
        logic [7:0]  exp_out;
        logic        uf;
    } vec_t;

    vec_t vecs[10];

    logic [36:0] outq[$];
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && valid_out && ready_in) outq.push_back({shift, normalized});
    end

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] e_exp;
        logic       e_uf;
`ifdef NORMALIZE_EXP_ADJUST_EN
        e_exp = v.exp_out;
        e_uf  = v.uf;
`else
        e_exp = 8'd0;
        e_uf  = 1'b0;
`endif
        operand = v.op; exponent_in = v.exp_in; valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_ready", idx), {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check($sformatf("vec%0d_lat1_valid", idx), {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("vec%0d_valid", idx), {31'd0, valid_out}, 32'd1);
        check($sformatf("vec%0d_norm", idx), normalized, v.norm);
        check($sformatf("vec%0d_shift", idx), {27'd0, shift}, {27'd0, v.sh});
        check($sformatf("vec%0d_zero", idx), {31'd0, is_zero}, {31'd0, v.zero});
        check($sformatf("vec%0d_exp", idx), {24'd0, exponent_out}, {24'd0, e_exp});
        check($sformatf("vec%0d_uf", idx), {31'd0, underflow}, {31'd0, e_uf});
        @(posedge clk); #1;
        check($sformatf("vec%0d_drain", idx), {31'd0, valid_out}, 32'd0);
    endtask

    task automatic run24(input logic [23:0] op, input logic [23:0] e_norm,
                         input logic [4:0] e_sh, input logic e_zero, input int idx);
        op24 = op; v24_in = 1'b1; r24_in = 1'b1;
        @(posedge clk); #1;
        v24_in = 1'b0;
        check($sformatf("w24_%0d_lat1", idx), {31'd0, v24_out}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("w24_%0d_valid", idx), {31'd0, v24_out}, 32'd1);
        check($sformatf("w24_%0d_norm", idx), {8'd0, norm24}, {8'd0, e_norm});
        check($sformatf("w24_%0d_shift", idx), {27'd0, sh24}, {27'd0, e_sh});
        check($sformatf("w24_%0d_zero", idx), {31'd0, z24}, {31'd0, e_zero});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h0000_0001, 8'd40,  32'h8000_0000, 5'd31, 1'b0, 8'd9,   1'b0};
        vecs[1] = '{32'h8000_0000, 8'd5,   32'h8000_0000, 5'd0,  1'b0, 8'd5,   1'b0};
        vecs[2] = '{32'h0000_0000, 8'd77,  32'h0000_0000, 5'd0,  1'b1, 8'd0,   1'b0};
        vecs[3] = '{32'h0000_0100, 8'd10,  32'h8000_0000, 5'd23, 1'b0, 8'hF3,  1'b1};
        vecs[4] = '{32'h0000_0100, 8'd40,  32'h8000_0000, 5'd23, 1'b0, 8'd17,  1'b0};
        vecs[5] = '{32'h0001_2345, 8'd15,  32'h91A2_8000, 5'd15, 1'b0, 8'd0,   1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 8'd0,   32'hFFFF_FFFE, 5'd1,  1'b0, 8'hFF,  1'b1};
        vecs[7] = '{32'h4000_0000, 8'd1,   32'h8000_0000, 5'd1,  1'b0, 8'd0,   1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 8'd255, 32'hFFFF_FFFF, 5'd0,  1'b0, 8'd255, 1'b0};
        vecs[9] = '{32'h0000_0003, 8'd200, 32'hC000_0000, 5'd30, 1'b0, 8'd170, 1'b0};

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; operand = 32'd0; exponent_in = 8'd0;
        v24_in = 1'b0; r24_in = 1'b1; op24 = 24'd0; exp24_in = 8'd0;
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_norm", normalized, 32'd0);
        check("rst_shift", {27'd0, shift}, 32'd0);
        check("rst_zero", {31'd0, is_zero}, 32'd0);
        check("rst_exp", {24'd0, exponent_out}, 32'd0);
        check("rst_uf", {31'd0, underflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_ready", {31'd0, ready_out}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        run24(24'h000F00, 24'hF00000, 5'd12, 1'b0, 0);
        run24(24'h000001, 24'h800000, 5'd23, 1'b0, 1);
        run24(24'h000000, 24'h000000, 5'd0,  1'b1, 2);
        run24(24'h800000, 24'h800000, 5'd0,  1'b0, 3);

        // Back-to-back stream with a three-cycle stall on the second output.
        outq.delete();
        mon_en = 1'b1;
        fork
            begin : drv
                logic [31:0] items[4];
                logic        ok;
                items = '{32'h1, 32'h2, 32'h4, 32'h8};
                for (int k = 0; k < 4; k++) begin
                    operand  = items[k];
                    valid_in = 1'b1;
                    for (int w = 0; w < 20; w++) begin
                        @(negedge clk);
                        ok = ready_out;
                        @(posedge clk); #1;
                        if (ok) break;
                    end
                end
                valid_in = 1'b0;
            end
            begin : rdy
                ready_in = 1'b1;
                repeat (3) @(posedge clk);
                #1 ready_in = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d_valid", c), {31'd0, valid_out}, 32'd1);
                    check($sformatf("stall%0d_shift", c), {27'd0, shift}, 32'd30);
                    check($sformatf("stall%0d_norm", c), normalized, 32'h8000_0000);
                    check($sformatf("stall%0d_ready", c), {31'd0, ready_out}, 32'd0);
                    @(posedge clk); #1;
                end
                ready_in = 1'b1;
            end
        join
        for (int w = 0; w < 30 && outq.size() < 4; w++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("stream_count", outq.size(), 32'd4);
        for (int i = 0; i < 4 && i < outq.size(); i++) begin
            check($sformatf("stream%0d_shift", i), {27'd0, outq[i][36:32]}, 32'(31 - i));
            check($sformatf("stream%0d_norm", i), outq[i][31:0], 32'h8000_0000);
        end

        // Reset with two items in flight.
        @(posedge clk); #1;
        ready_in = 1'b1; operand = 32'h3; valid_in = 1'b1;
        @(posedge clk); #1;
        operand = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("inflight_valid", {31'd0, valid_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        check("mid_rst_norm", normalized, 32'd0);
        check("mid_rst_shift", {27'd0, shift}, 32'd0);
        check("mid_rst_zero", {31'd0, is_zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rel_ready", {31'd0, ready_out}, 32'd1);
        check("rel_valid", {31'd0, valid_out}, 32'd0);
        operand = 32'h10; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("after_rst_lat1", {31'd0, valid_out}, 32'd0);
        @(posedge clk); #1;
        check("after_rst_valid", {31'd0, valid_out}, 32'd1);
        check("after_rst_shift", {27'd0, shift}, 32'd27);
        check("after_rst_norm", normalized, 32'h8000_0000);
        @(posedge clk); #1;
        check("after_rst_empty", {31'd0, valid_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
